// File: rtl/accum_alu_pkg.sv
// Shared definitions for the accumulating ALU: operation select encoding.
package accum_alu_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SUB  = 2'd1,
        MODE_ACC  = 2'd2,
        MODE_LOAD = 2'd3
    } mode_t;

endpackage

// File: rtl/accum_alu_core.sv
// Combinational datapath of the accumulating ALU: sum, difference, accumulate and flag.
// Clamping instead of wrap-around is selected by defining ACCUM_ALU_SATURATE_EN.
module accum_alu_core
    import accum_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       mode,
    input  logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] value,
    output logic             flag
);

    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] diff;
    logic             borrow;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] sub_value;
    logic [ACC_W-1:0] acc_value;

    assign a_ext   = {{(ACC_W-WIDTH){1'b0}}, op_a};
    assign b_ext   = {{(ACC_W-WIDTH){1'b0}}, op_b};
    // ACC_W > WIDTH, so the operand sum can never overflow the result width.
    assign sum     = a_ext + b_ext;
    assign diff    = a_ext - b_ext;
    assign borrow  = (op_a < op_b);
    assign acc_sum = {1'b0, acc} + {1'b0, sum};

`ifdef ACCUM_ALU_SATURATE_EN
    assign sub_value = borrow ? '0 : diff;
    assign acc_value = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
    assign sub_value = diff;
    assign acc_value = acc_sum[ACC_W-1:0];
`endif

    always_comb begin
        value = sum;
        flag  = 1'b0;
        case (mode_t'(mode))
            MODE_ADD:  begin value = sum;       flag = 1'b0;           end
            MODE_SUB:  begin value = sub_value; flag = borrow;         end
            MODE_ACC:  begin value = acc_value; flag = acc_sum[ACC_W]; end
            MODE_LOAD: begin value = sum;       flag = 1'b0;           end
            default:   begin value = sum;       flag = 1'b0;           end
        endcase
    end

endmodule

// File: rtl/accum_alu.sv
// Accumulating ALU with valid/ready handshake and a single-entry output register.
// Define ACCUM_ALU_SATURATE_EN to clamp SUB/ACC results instead of wrapping.
module accum_alu
    import accum_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             carry
);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] result_reg;
    logic             carry_reg;
    logic             out_valid_reg;
    logic [ACC_W-1:0] core_value;
    logic             core_flag;
    logic             accept;
    logic             acc_write;

    accum_alu_core #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_core (
        .op_a  (op_a),
        .op_b  (op_b),
        .mode  (mode),
        .acc   (acc_reg),
        .value (core_value),
        .flag  (core_flag)
    );

    // The output register is free if empty or being drained this cycle.
    assign in_ready  = !out_valid_reg || out_ready;
    assign accept    = in_valid && in_ready;
    // ACC and LOAD both leave the new accumulator value on the core output.
    assign acc_write = (mode_t'(mode) == MODE_ACC) || (mode_t'(mode) == MODE_LOAD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg       <= '0;
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                result_reg    <= core_value;
                carry_reg     <= core_flag;
                out_valid_reg <= 1'b1;
                if (acc_write) begin
                    acc_reg <= core_value;
                end
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign carry     = carry_reg;

endmodule
